dot2_pipeline: RTL and testbench
================================

# dot2_pipeline

Two-stage pipelined two-term dot-product unit that computes C = A1·B1 + A2·B2 on 32-bit operands. Stage 1 forms both products in parallel. Stage 2 adds them into the registered output. It is the datapath primitive used by the `pipeline` module: a free-running, fully pipelined block that accepts a new operand set every clock and has no handshake.

## Interface
- WIDTH, 32, operand/result width in bits; all ports and internal registers use it.
- clk  in  1  rising-edge clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all pipeline registers and C.
- A1  in  WIDTH  first multiplicand of term 1.
- B1  in  WIDTH  second multiplicand of term 1.
- A2  in  WIDTH  first multiplicand of term 2.
- B2  in  WIDTH  second multiplicand of term 2.
- C  out  WIDTH  registered result A1·B1 + A2·B2, two clocks after the operands are sampled.

## Operation
- Stage 1 registers P1 and P2, each WIDTH bits.
  - On posedge: P1 <= A1*B1, P2 <= A2*B2.
  - Each product keeps only its low WIDTH bits; upper bits are discarded.
- Stage 2 output register C.
  - On posedge: C <= P1 + P2, modulo 2^WIDTH; the carry-out is discarded.
- Arithmetic is unsigned.
  - The low WIDTH bits equal the two's-complement result, so the same hardware serves signed operands. No overflow flag.
- No valid, enable or stall signals. Inputs are sampled on every posedge and C updates on every posedge.
- C is driven directly from a register, with no combinational path from inputs to C.
- Reset (asynchronous, active-high):
  - While reset=1: P1, P2 and C are 0 immediately, independent of clk.
  - Reset takes priority over any simultaneous clock edge.

## Timing
- Latency is 2 rising edges. Operands stable at posedge N appear on C after posedge N+1.
- Throughput is one result per clock. Back-to-back operand sets produce back-to-back results in order.
- Operand setup and hold are relative to posedge only. Changes between edges have no effect until the next edge.
- Holding operands constant across several edges:
  - C is valid from the second edge onward.
  - C stays constant afterwards.
- After reset deasserts:
  - First posedge: C = 0 + 0 = 0, and P1/P2 load the current operands.
  - Second posedge: C shows the result for the operands sampled at the first edge.
- Reset asserted mid-operation: all in-flight results are lost, with no partial update. Operation restarts as in the post-reset case.
- Reset deassertion need not be synchronised inside the block; the system provides reset release clear of clk edges.

## Test plan
- Reset check:
  - Stimulus: reset=1 with arbitrary operands, no clock.
  - Required response: C=0 immediately.
  - Then: release reset with A1=B1=A2=B2=0 and apply 2 edges; C stays 0.
- Basic two-edge latency:
  - Stimulus: A1=0, B1=1, A2=2, B2=3.
  - Required response: after the 1st edge C is unchanged (0); after the 2nd edge C=6.
- Operand change mid-stream:
  - Stimulus: from the state above, set A1=3, B1=1, A2=2, B2=0.
  - Required response: after the next edge C=6 still; after the following edge C=3.
- Back-to-back throughput:
  - Stimulus: sets {1,1,1,1}, {2,2,2,2}, {3,3,3,3} applied on consecutive edges.
  - Required response: C=2, 8, 18 on consecutive edges starting at the 2nd edge.
- Wrap-around:
  - Product truncation: A1=0x10000, B1=0x10000, A2=B2=0 gives C=0.
  - Sum overflow: A1=0xFFFFFFFF, B1=1, A2=1, B2=1 gives C=0.
  - Signed case: A1=0xFFFFFFFF (−1), B1=5, A2=7, B2=1 gives C=2.
- Async reset mid-pipeline:
  - Stimulus: load A1=B1=A2=B2=4, apply 1 edge, then pulse reset between edges.
  - Required response: C=0 immediately.
  - Then: with the operands still 4, the next edge gives C=0 and the one after gives C=32.

Source files
------------

// File: rtl/dot2_pipeline_if.sv
// Operand/result bundle for the two-term dot-product pipeline.
// The master drives the four operands each clock; the slave returns the registered result.
interface dot2_pipeline_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A1;
  logic [WIDTH-1:0] B1;
  logic [WIDTH-1:0] A2;
  logic [WIDTH-1:0] B2;
  logic [WIDTH-1:0] C;

  modport master (
    output A1,
    output B1,
    output A2,
    output B2,
    input  C
  );

  modport slave (
    input  A1,
    input  B1,
    input  A2,
    input  B2,
    output C
  );
endinterface

// File: rtl/dot2_pipeline.sv
// Two-stage C = A1*B1 + A2*B2, modulo 2^WIDTH, one new operand set per clock.
// Stage 1 registers both truncated products; stage 2 registers their sum.
module dot2_pipeline #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  dot2_pipeline_if.slave  bus
);

  logic [WIDTH-1:0] p1;
  logic [WIDTH-1:0] p2;
  logic [WIDTH-1:0] c_q;

  // Unsigned wrap-around arithmetic; low bits match two's-complement results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1  <= '0;
      p2  <= '0;
      c_q <= '0;
    end else begin
      p1  <= bus.A1 * bus.B1;
      p2  <= bus.A2 * bus.B2;
      c_q <= p1 + p2;
    end
  end

  assign bus.C = c_q;

endmodule

// File: tb/tb_dot2_pipeline.sv
// Directed-vector bench for dot2_pipeline with a queue scoreboard and an
// independent monitor that checks C shortly after every rising edge.
module tb_dot2_pipeline;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] a2;
    logic [WIDTH-1:0] b2;
    logic [WIDTH-1:0] exp;
  } vec_t;

  logic clk;
  logic reset;
  logic run;
  int   total;
  int   bad;
  int   vec_num;

  vec_t             vecs[$];
  logic [WIDTH-1:0] exp_q[$];
  int               tag_q[$];

  dot2_pipeline_if #(.WIDTH(WIDTH)) bus ();

  dot2_pipeline #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    wait (run);
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: C=%0h expected %0h", name, got, want);
    end
  endtask

  task automatic add_vec(input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                         input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] b2,
                         input logic [WIDTH-1:0] exp);
    vec_t v;
    v.a1 = a1; v.b1 = b1; v.a2 = a2; v.b2 = b2; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Monitor: every rising edge produces one result, matched against the queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_edge: no expected value queued, C=%0h", bus.C);
      end else begin
        logic [WIDTH-1:0] want;
        int               tag;
        want = exp_q.pop_front();
        tag  = tag_q.pop_front();
        check($sformatf("vec%0d", tag), bus.C, want);
      end
    end
  end

  initial begin
    total   = 0;
    bad     = 0;
    run     = 1'b0;
    vec_num = 0;

    // exp is the value C must show after the edge that samples this vector.
    add_vec(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    add_vec(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    add_vec(32'd0, 32'd1, 32'd2, 32'd3, 32'd0);
    add_vec(32'd0, 32'd1, 32'd2, 32'd3, 32'd6);
    add_vec(32'd3, 32'd1, 32'd2, 32'd0, 32'd6);
    add_vec(32'd3, 32'd1, 32'd2, 32'd0, 32'd3);
    add_vec(32'd1, 32'd1, 32'd1, 32'd1, 32'd3);
    add_vec(32'd2, 32'd2, 32'd2, 32'd2, 32'd2);
    add_vec(32'd3, 32'd3, 32'd3, 32'd3, 32'd8);
    add_vec(32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 32'd18);
    add_vec(32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1, 32'd0);
    add_vec(32'hFFFF_FFFF, 32'd5, 32'd7, 32'd1, 32'd0);
    add_vec(32'hFFFF_FFFF, 32'd5, 32'd7, 32'd1, 32'd2);
    add_vec(32'd4, 32'd4, 32'd4, 32'd4, 32'd2);
    // Reset pulse is inserted before the next vector.
    add_vec(32'd4, 32'd4, 32'd4, 32'd4, 32'd0);
    add_vec(32'd4, 32'd4, 32'd4, 32'd4, 32'd32);
    add_vec(32'd0, 32'd0, 32'd0, 32'd0, 32'd32);
    add_vec(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

    // Reset with arbitrary operands and no clock running.
    bus.A1 = 32'h1234_5678;
    bus.B1 = 32'h9abc_def0;
    bus.A2 = 32'h0f0f_0f0f;
    bus.B2 = 32'hdead_beef;
    reset  = 1'b1;
    #1;
    check("reset_no_clock", bus.C, 32'd0);

    foreach (vecs[i]) begin
      if (i > 0) @(negedge clk);
      if (i == 14) begin
        #1 reset = 1'b1;
        #1 check("reset_mid_pipeline", bus.C, 32'd0);
        #1 reset = 1'b0;
      end
      bus.A1 = vecs[i].a1;
      bus.B1 = vecs[i].b1;
      bus.A2 = vecs[i].a2;
      bus.B2 = vecs[i].b2;
      exp_q.push_back(vecs[i].exp);
      tag_q.push_back(i);
      if (i == 0) begin
        #1 reset = 1'b0;
        run = 1'b1;
      end
      vec_num++;
    end

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
